// File: rtl/gamepad_pkg.sv
// Shared types and scan-code tables for the PS/2 gamepad front end.
// Key map rows are indexed by player, columns by key_idx_t.
package gamepad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    KEY_UP    = 2'd0,
    KEY_DOWN  = 2'd1,
    KEY_LEFT  = 2'd2,
    KEY_RIGHT = 2'd3
  } key_idx_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
  } key_code_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;

  localparam int MAX_PLAYERS = 2;
  localparam int NUM_KEYS    = 4;

  localparam key_code_t KEY_MAP [MAX_PLAYERS][NUM_KEYS] = '{
    '{'{8'h1D, 1'b0}, '{8'h1B, 1'b0}, '{8'h1C, 1'b0}, '{8'h23, 1'b0}},
    '{'{8'h75, 1'b1}, '{8'h72, 1'b1}, '{8'h6B, 1'b1}, '{8'h74, 1'b1}}
  };

endpackage

// File: rtl/ps2_make_break_decoder.sv
// Folds E0/F0 prefixes into single make/break events. The event outputs are
// combinational on the accepted byte so the consumer registers them in the same cycle.
module ps2_make_break_decoder
  import gamepad_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_key,
  input  logic       i_key_valid,
  output logic       o_evt,
  output logic [7:0] o_code,
  output logic       o_ext,
  output logic       o_brk
);

  dec_state_t state, state_nxt;

  always_comb begin
    state_nxt = state;
    o_evt     = 1'b0;
    o_code    = i_key;
    o_ext     = 1'b0;
    o_brk     = 1'b0;
    if (i_key_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (i_key == SC_E0)      state_nxt = ST_EXT;
          else if (i_key == SC_F0) state_nxt = ST_BRK;
          else if (i_key != SC_E1) o_evt = 1'b1;
        end
        ST_EXT: begin
          if (i_key == SC_F0) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            o_evt     = 1'b1;
            o_ext     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          o_evt     = 1'b1;
          o_brk     = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          o_evt     = 1'b1;
          o_ext     = 1'b1;
          o_brk     = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

endmodule

// File: rtl/keyboard_gamepad_multi.sv
// Per-player platform movement, shoot/gadget pulses and shoot cooldown driven
// by decoded PS/2 make/break events.
module keyboard_gamepad_multi
  import gamepad_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int XW          = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int X_INIT      = 320,
  parameter int STEP        = 10,
  parameter int COOLDOWN    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_key,
  input  logic                      i_key_valid,
  input  logic                      i_tick,
  output logic [NUM_PLAYERS*XW-1:0] o_platX,
  output logic [NUM_PLAYERS-1:0]    o_shoot,
  output logic [NUM_PLAYERS-1:0]    o_use_gadget,
  output logic [NUM_PLAYERS-1:0]    o_debug_shoot
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [XW-1:0] X_MIN_V  = XW'(X_MIN);
  localparam logic [XW-1:0] X_MAX_V  = XW'(X_MAX);
  localparam logic [XW-1:0] X_INIT_V = XW'(X_INIT);
  localparam logic [XW-1:0] STEP_V   = XW'(STEP);
  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN);

  logic       dec_evt;
  logic [7:0] dec_code;
  logic       dec_ext;
  logic       dec_brk;

  ps2_make_break_decoder u_dec (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key       (i_key),
    .i_key_valid (i_key_valid),
    .o_evt       (dec_evt),
    .o_code      (dec_code),
    .o_ext       (dec_ext),
    .o_brk       (dec_brk)
  );

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] held;
    logic [XW-1:0]       plat_x;
    logic [CW-1:0]       cooldown;
    logic                shoot_q, gadget_q, dbg_q;
    logic                fire, fresh_down, go_left, go_right;

    always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        match[k] = dec_evt && (dec_code == KEY_MAP[p][k].code) &&
                   (dec_ext == KEY_MAP[p][k].ext);
      end
    end

    // A make on an already-held key is typematic repeat and must not pulse.
    assign fire       = match[KEY_UP] & ~dec_brk & ~held[KEY_UP] & (cooldown == '0);
    assign fresh_down = match[KEY_DOWN] & ~dec_brk & ~held[KEY_DOWN];
    assign go_left    = held[KEY_LEFT] & ~held[KEY_RIGHT];
    assign go_right   = held[KEY_RIGHT] & ~held[KEY_LEFT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        held     <= '0;
        plat_x   <= X_INIT_V;
        cooldown <= '0;
        shoot_q  <= 1'b0;
        gadget_q <= 1'b0;
        dbg_q    <= 1'b0;
      end else begin
        shoot_q  <= fire;
        gadget_q <= fresh_down;
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (match[k]) held[k] <= ~dec_brk;
        end
        if (fire) dbg_q <= ~dbg_q;
        // fire needs cooldown==0 and decrement needs !=0, so they never collide.
        if (fire)                          cooldown <= CD_LOAD;
        else if (i_tick && cooldown != '0) cooldown <= cooldown - 1'b1;
        if (i_tick) begin
          if (go_left) begin
            if (int'(plat_x) < X_MIN + STEP) plat_x <= X_MIN_V;
            else                             plat_x <= plat_x - STEP_V;
          end else if (go_right) begin
            if (int'(plat_x) > X_MAX - STEP) plat_x <= X_MAX_V;
            else                             plat_x <= plat_x + STEP_V;
          end
        end
      end
    end

    assign o_platX[p*XW +: XW] = plat_x;
    assign o_shoot[p]          = shoot_q;
    assign o_use_gadget[p]     = gadget_q;
    assign o_debug_shoot[p]    = dbg_q;
  end

endmodule
